// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller between IF/MEM and an 8-bit single-port RAM.
// Ports: clk/rst, IF fetch req/addr/inst/done, MEM req/we/sel/addr/wdata/rdata/done,
// stallreq_if_o/stallreq_mem_o to ctrl, registered RAM addr/rw/dout, ram_din_i.
// Optional FETCH_BUF_EN adds a one-entry fetch buffer.
module mem_ctrl #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic [31:0]       if_inst_o,
   output logic              if_done_o,
   output logic              stallreq_if_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [2:0]        mem_sel_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic              stallreq_mem_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_rw_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i
);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d, n_q, n_d, n_sel;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d, asm_q, asm_d, asm_w;
   logic              drop_q, drop_d, drop_now, last_rd;
   logic [31:0]       if_inst_q, if_inst_d, mem_rdata_q, mem_rdata_d;
   logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_rw_q, ram_rw_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic [1:0]        rd_lane, wr_lane;
   logic              unused_addr;

`ifdef FETCH_BUF_EN
   logic              fb_valid_q, fb_valid_d, fb_hit;
   logic [ADDR_W-3:0] fb_tag_q, fb_tag_d;
   logic [31:0]       fb_data_q, fb_data_d;

   assign fb_hit = fb_valid_q && (fb_tag_q == if_addr_i[ADDR_W-1:2]);
`endif

   assign unused_addr = ^{if_addr_i[31:ADDR_W], if_addr_i[1:0],
                          mem_addr_i[31:ADDR_W]};

   assign if_inst_o      = if_inst_q;
   assign if_done_o      = if_done_q;
   assign mem_rdata_o    = mem_rdata_q;
   assign mem_done_o     = mem_done_q;
   assign ram_addr_o     = ram_addr_q;
   assign ram_rw_o       = ram_rw_q;
   assign ram_dout_o     = ram_dout_q;
   assign stallreq_if_o  = if_req_i & ~if_done_q;
   assign stallreq_mem_o = mem_req_i & ~mem_done_q;

   // ram_din_i always belongs to the address issued one cycle earlier
   assign rd_lane  = cnt_q[1:0] - 2'd1;
   assign wr_lane  = cnt_q[1:0] + 2'd1;
   assign last_rd  = (cnt_q == n_q);
   // a requester that let go at any point loses its done pulse
   assign drop_now = drop_q | ~((state_q == FETCH) ? if_req_i : mem_req_i);

   always_comb begin
      case (mem_sel_i)
         3'b001:  n_sel = 3'd1;
         3'b010:  n_sel = 3'd2;
         default: n_sel = 3'd4;
      endcase
   end

   always_comb begin
      asm_w = asm_q;
      asm_w[{rd_lane, 3'b000} +: 8] = ram_din_i;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         n_q         <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         asm_q       <= '0;
         drop_q      <= 1'b0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_rw_q    <= 1'b0;
         ram_dout_q  <= '0;
`ifdef FETCH_BUF_EN
         fb_valid_q  <= 1'b0;
         fb_tag_q    <= '0;
         fb_data_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         drop_q      <= drop_d;
         if_inst_q   <= if_inst_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         ram_addr_q  <= ram_addr_d;
         ram_rw_q    <= ram_rw_d;
         ram_dout_q  <= ram_dout_d;
`ifdef FETCH_BUF_EN
         fb_valid_q  <= fb_valid_d;
         fb_tag_q    <= fb_tag_d;
         fb_data_q   <= fb_data_d;
`endif
      end
   end

   // next state: MEM wins arbitration in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (mem_req_i) begin
               state_d = mem_we_i ? STORE : LOAD;
            end else if (if_req_i) begin
`ifdef FETCH_BUF_EN
               state_d = fb_hit ? DONE : FETCH;
`else
               state_d = FETCH;
`endif
            end
         end
         FETCH, LOAD: if (last_rd) state_d = DONE;
         STORE: if (cnt_q == n_q - 3'd1) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath and outputs
   always_comb begin
      cnt_d       = cnt_q;
      n_d         = n_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      asm_d       = asm_q;
      drop_d      = drop_q;
      if_inst_d   = if_inst_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_rw_d    = 1'b0;
      ram_dout_d  = ram_dout_q;
`ifdef FETCH_BUF_EN
      fb_valid_d  = fb_valid_q;
      fb_tag_d    = fb_tag_q;
      fb_data_d   = fb_data_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            drop_d = 1'b0;
            asm_d  = '0;
            if (mem_req_i) begin
               n_d        = n_sel;
               base_d     = mem_addr_i[ADDR_W-1:0];
               wdata_d    = mem_wdata_i;
               ram_addr_d = mem_addr_i[ADDR_W-1:0];
               ram_rw_d   = mem_we_i;
               if (mem_we_i) ram_dout_d = mem_wdata_i[7:0];
            end else if (if_req_i) begin
               n_d        = 3'd4;
               base_d     = if_addr_i[ADDR_W-1:0];
               ram_addr_d = if_addr_i[ADDR_W-1:0];
`ifdef FETCH_BUF_EN
               if (fb_hit) begin
                  ram_addr_d = ram_addr_q;
                  if_inst_d  = fb_data_q;
                  if_done_d  = 1'b1;
               end
`endif
            end
         end
         FETCH, LOAD: begin
            cnt_d  = cnt_q + 3'd1;
            drop_d = drop_now;
            if (cnt_q != 3'd0) asm_d = asm_w;
            if (cnt_q < n_q - 3'd1)
               ram_addr_d = base_q + ADDR_W'(cnt_q + 3'd1);
            if (last_rd && !drop_now) begin
               if (state_q == FETCH) begin
                  if_inst_d = asm_w;
                  if_done_d = 1'b1;
`ifdef FETCH_BUF_EN
                  fb_valid_d = 1'b1;
                  fb_tag_d   = base_q[ADDR_W-1:2];
                  fb_data_d  = asm_w;
`endif
               end else begin
                  mem_rdata_d = asm_w;
                  mem_done_d  = 1'b1;
               end
            end
         end
         STORE: begin
            cnt_d  = cnt_q + 3'd1;
            drop_d = drop_now;
            if (cnt_q < n_q - 3'd1) begin
               ram_addr_d = base_q + ADDR_W'(cnt_q + 3'd1);
               ram_rw_d   = 1'b1;
               ram_dout_d = wdata_q[{wr_lane, 3'b000} +: 8];
            end else if (!drop_now) begin
               mem_done_d = 1'b1;
            end
         end
         default: ;
      endcase
`ifdef FETCH_BUF_EN
      // any byte written into the buffered word makes it stale
      if (ram_rw_d && (ram_addr_d[ADDR_W-1:2] == fb_tag_q))
         fb_valid_d = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a byte RAM model
// and a transaction-level reference memory / fetch-buffer model.
module tb_mem_ctrl;

   localparam int AW   = 17;
   localparam int MASK = (1 << AW) - 1;
`ifdef FETCH_BUF_EN
   localparam int HIT_LAT = 1;
   localparam bit HAS_FB  = 1'b1;
`else
   localparam int HIT_LAT = 6;
   localparam bit HAS_FB  = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [31:0]   if_addr = '0;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [2:0]    mem_sel = 3'b100;
   logic [31:0]   mem_addr = '0;
   logic [31:0]   mem_wdata = '0;
   logic [31:0]   if_inst_o, mem_rdata_o;
   logic          if_done_o, mem_done_o, stallreq_if_o, stallreq_mem_o;
   logic [AW-1:0] ram_addr_o;
   logic          ram_rw_o;
   logic [7:0]    ram_dout_o;
   logic [7:0]    ram_din_i = '0;

   int checks = 0;
   int errors = 0;

   logic [7:0]    ram [0:(1<<AW)-1];
   logic          bk_we = 1'b0;
   logic [AW-1:0] bk_addr = '0;
   logic [7:0]    bk_data = '0;
   logic [7:0]    ref_mem [int];
   bit            mfb_v;
   int            mfb_w;

   always #5 clk = ~clk;

   mem_ctrl #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_inst_o(if_inst_o),
      .if_done_o(if_done_o), .stallreq_if_o(stallreq_if_o),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
      .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
      .stallreq_mem_o(stallreq_mem_o),
      .ram_addr_o(ram_addr_o), .ram_rw_o(ram_rw_o),
      .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
   );

   // synchronous-read RAM with a backdoor preload port
   always @(posedge clk) begin
      if (bk_we) ram[bk_addr] <= bk_data;
      else if (ram_rw_o) ram[ram_addr_o] <= ram_dout_o;
      ram_din_i <= ram[ram_addr_o];
   end

   function automatic int nbytes(input logic [2:0] s);
      if (s == 3'b001) return 1;
      if (s == 3'b010) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
      logic [31:0] r = '0;
      for (int k = 0; k < n; k++)
         r[8*k +: 8] = ref_mem[int'((a + 32'(k)) & MASK)];
      return r;
   endfunction

   function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
      logic [31:0] r = '0;
      for (int k = 0; k < n; k++)
         r[8*k +: 8] = ram[int'((a + 32'(k)) & MASK)];
      return r;
   endfunction

   task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] wd);
      for (int k = 0; k < n; k++) begin
         ref_mem[int'((a + 32'(k)) & MASK)] = wd[8*k +: 8];
         if (mfb_v && (int'(((a + 32'(k)) & MASK) >> 2) == mfb_w)) mfb_v = 1'b0;
      end
   endtask

   task automatic poke(input int a, input logic [7:0] d);
      bk_we = 1'b1;
      bk_addr = AW'(a);
      bk_data = d;
      ref_mem[a & MASK] = d;
      @(posedge clk);
      #1 bk_we = 1'b0;
   endtask

   // kind: 0 fetch, 1 load, 2 store; lat = cycles from request to done
   task automatic run_op(input int kind, input logic [2:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data,
                         output bit sok);
      bit got = 1'b0;
      bit dn, st;
      lat = 0;
      data = '0;
      sok = 1'b1;
      @(posedge clk);
      #1;
      if (kind == 0) begin
         if_req = 1'b1;
         if_addr = addr;
      end else begin
         mem_req = 1'b1;
         mem_we = (kind == 2);
         mem_sel = sel;
         mem_addr = addr;
         mem_wdata = wd;
      end
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         dn = (kind == 0) ? if_done_o : mem_done_o;
         st = (kind == 0) ? stallreq_if_o : stallreq_mem_o;
         if (dn) begin
            got = 1'b1;
            data = (kind == 0) ? if_inst_o : mem_rdata_o;
            if (st) sok = 1'b0;
         end else begin
            if (!st) sok = 1'b0;
            @(posedge clk);
            #1 lat++;
         end
      end
      if (!got) lat = -1;
      if_req = 1'b0;
      mem_req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (if_inst_o !== 32'h0) begin errors++; $display("FAIL rst_if_inst got=%h exp=0", if_inst_o); end
      checks++; if (mem_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_mem_rdata got=%h exp=0", mem_rdata_o); end
      checks++; if (if_done_o !== 1'b0) begin errors++; $display("FAIL rst_if_done got=%b exp=0", if_done_o); end
      checks++; if (mem_done_o !== 1'b0) begin errors++; $display("FAIL rst_mem_done got=%b exp=0", mem_done_o); end
      checks++; if (ram_addr_o !== '0) begin errors++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr_o); end
      checks++; if (ram_rw_o !== 1'b0) begin errors++; $display("FAIL rst_ram_rw got=%b exp=0", ram_rw_o); end
      checks++; if (ram_dout_o !== 8'h0) begin errors++; $display("FAIL rst_ram_dout got=%h exp=0", ram_dout_o); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_fetch_basic();
      int lat; logic [31:0] d; bit sok;
      poke(0, 8'h13); poke(1, 8'h00); poke(2, 8'h00); poke(3, 8'h00);
      run_op(0, 3'b100, 32'h0, 32'h0, lat, d, sok);
      checks++; if (lat !== 6) begin errors++; $display("FAIL fetch_lat got=%0d exp=6", lat); end
      checks++; if (d !== 32'h13) begin errors++; $display("FAIL fetch_data got=%h exp=00000013", d); end
      checks++; if (!sok) begin errors++; $display("FAIL fetch_stall got=0 exp=1 until done"); end
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] d; bit sok;
      run_op(2, 3'b100, 32'h100, 32'hDEADBEEF, lat, d, sok);
      model_store(32'h100, 4, 32'hDEADBEEF);
      checks++; if (lat !== 5) begin errors++; $display("FAIL store_lat got=%0d exp=5", lat); end
      checks++; if (!sok) begin errors++; $display("FAIL store_stall got=0 exp=1 until done"); end
      checks++; if (ram_word(32'h100, 4) !== 32'hDEADBEEF) begin errors++; $display("FAIL store_bytes got=%h exp=deadbeef", ram_word(32'h100, 4)); end
      run_op(1, 3'b001, 32'h101, 32'h0, lat, d, sok);
      checks++; if (lat !== 3) begin errors++; $display("FAIL lb_lat got=%0d exp=3", lat); end
      checks++; if (d !== 32'hBE) begin errors++; $display("FAIL lb_data got=%h exp=000000be", d); end
      run_op(1, 3'b010, 32'h102, 32'h0, lat, d, sok);
      checks++; if (lat !== 4) begin errors++; $display("FAIL lh_lat got=%0d exp=4", lat); end
      checks++; if (d !== 32'hDEAD) begin errors++; $display("FAIL lh_data got=%h exp=0000dead", d); end
      // sel 000 acts as a word; bit 17 of the address is dropped
      run_op(1, 3'b000, 32'h20100, 32'h0, lat, d, sok);
      checks++; if (lat !== 6) begin errors++; $display("FAIL lw_wrap_lat got=%0d exp=6", lat); end
      checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wrap_data got=%h exp=deadbeef", d); end
   endtask

   task automatic test_arbitration();
      int md = -1, fd = -1;
      logic [31:0] dm = '0, di = '0, exp_m, exp_f;
      bit sok = 1'b1;
      for (int k = 0; k < 4; k++) poke(32'h200 + k, 8'($urandom));
      exp_f = ref_load(32'h200, 4);
      exp_m = ref_load(32'h104, 4);
      @(posedge clk);
      #1;
      if_req = 1'b1; if_addr = 32'h200;
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 3'b100; mem_addr = 32'h104;
      for (int c = 0; c < 40 && fd < 0; c++) begin
         @(negedge clk);
         if (mem_done_o && md < 0) begin md = c; dm = mem_rdata_o; mem_req = 1'b0; end
         if (if_done_o) begin fd = c; di = if_inst_o; if_req = 1'b0; end
         else if (!stallreq_if_o) sok = 1'b0;
         @(posedge clk);
         #1;
      end
      if_req = 1'b0; mem_req = 1'b0;
      checks++; if (md !== 6) begin errors++; $display("FAIL arb_mem_done got=%0d exp=6", md); end
      checks++; if (dm !== exp_m) begin errors++; $display("FAIL arb_mem_data got=%h exp=%h", dm, exp_m); end
      checks++; if (fd !== md + 7) begin errors++; $display("FAIL arb_if_done got=%0d exp=%0d", fd, md + 7); end
      checks++; if (di !== exp_f) begin errors++; $display("FAIL arb_if_data got=%h exp=%h", di, exp_f); end
      checks++; if (!sok) begin errors++; $display("FAIL arb_if_stall got=0 exp=1 while waiting"); end
   endtask

   task automatic test_reset_mid_store();
      int writes = 0;
      for (int k = 0; k < 4; k++) poke(32'h300 + k, 8'hAA);
      @(posedge clk);
      #1;
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 3'b100;
      mem_addr = 32'h300; mem_wdata = 32'h11223344;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      checks++; if (!(ram_rw_o === 1'b1 && ram_addr_o === AW'(32'h301) && ram_dout_o === 8'h33)) begin
         errors++; $display("FAIL rstmid_2nd_byte got=rw%b a%h d%h exp=rw1 a00301 d33", ram_rw_o, ram_addr_o, ram_dout_o); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (ram_rw_o !== 1'b0) begin errors++; $display("FAIL rstmid_rw got=%b exp=0", ram_rw_o); end
      checks++; if (ram_addr_o !== '0) begin errors++; $display("FAIL rstmid_addr got=%h exp=0", ram_addr_o); end
      checks++; if (ram_dout_o !== 8'h0) begin errors++; $display("FAIL rstmid_dout got=%h exp=0", ram_dout_o); end
      checks++; if (if_inst_o !== 32'h0 || mem_rdata_o !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h/%h exp=0/0", if_inst_o, mem_rdata_o); end
      checks++; if (if_done_o !== 1'b0 || mem_done_o !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b/%b exp=0/0", if_done_o, mem_done_o); end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) begin @(negedge clk); if (ram_rw_o) writes++; end
      model_store(32'h300, 2, 32'h11223344);
      checks++; if (writes !== 0) begin errors++; $display("FAIL rstmid_late_writes got=%0d exp=0", writes); end
      checks++; if (ram_word(32'h300, 4) !== 32'hAAAA3344) begin errors++; $display("FAIL rstmid_ram got=%h exp=aaaa3344", ram_word(32'h300, 4)); end
   endtask

   task automatic test_drop_mid_load();
      int lat; logic [31:0] d, prev; bit sok;
      logic [3:0] seen = '0;
      bit done_seen = 1'b0, wr_seen = 1'b0;
      run_op(1, 3'b100, 32'h100, 32'h0, lat, prev, sok);
      checks++; if (prev !== ref_load(32'h100, 4)) begin errors++; $display("FAIL drop_pre_load got=%h exp=%h", prev, ref_load(32'h100, 4)); end
      @(posedge clk);
      #1;
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 3'b100; mem_addr = 32'h108;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (!ram_rw_o && ram_addr_o >= AW'(32'h108) && ram_addr_o <= AW'(32'h10B)) seen[ram_addr_o[1:0]] = 1'b1;
         if (ram_rw_o) wr_seen = 1'b1;
         if (mem_done_o) done_seen = 1'b1;
         if (c == 2) mem_req = 1'b0;
      end
      checks++; if (seen !== 4'hF) begin errors++; $display("FAIL drop_reads got=%b exp=1111", seen); end
      checks++; if (done_seen) begin errors++; $display("FAIL drop_done got=1 exp=0"); end
      checks++; if (wr_seen) begin errors++; $display("FAIL drop_writes got=1 exp=0"); end
      checks++; if (mem_rdata_o !== prev) begin errors++; $display("FAIL drop_rdata got=%h exp=%h", mem_rdata_o, prev); end
      run_op(1, 3'b010, 32'h10A, 32'h0, lat, d, sok);
      checks++; if (lat !== 4 || d !== ref_load(32'h10A, 2)) begin errors++; $display("FAIL drop_after got=%0d/%h exp=4/%h", lat, d, ref_load(32'h10A, 2)); end
   endtask

   task automatic test_fetch_buf();
      int lat; logic [31:0] d; bit sok;
      int exp_lat [5] = '{6, HIT_LAT, HIT_LAT, 6, HIT_LAT};
      int step = 0;
      for (int k = 0; k < 4; k++) poke(32'h40 + k, 8'($urandom));
      for (int i = 0; i < 7; i++) begin
         if (i == 2) run_op(2, 3'b001, 32'h44, 32'h77, lat, d, sok);
         else if (i == 4) begin
            run_op(2, 3'b001, 32'h42, 32'h5A, lat, d, sok);
            model_store(32'h42, 1, 32'h5A);
         end else begin
            run_op(0, 3'b100, 32'h40, 32'h0, lat, d, sok);
            checks++; if (lat !== exp_lat[step]) begin errors++; $display("FAIL fbuf_lat%0d got=%0d exp=%0d", step, lat, exp_lat[step]); end
            checks++; if (d !== ref_load(32'h40, 4)) begin errors++; $display("FAIL fbuf_data%0d got=%h exp=%h", step, d, ref_load(32'h40, 4)); end
            step++;
         end
      end
   endtask

   task automatic test_random();
      int lat, kind, n, exp_lat;
      logic [31:0] d, a, wd, exp_d;
      logic [2:0] sel;
      bit sok;
      logic [2:0] sels [4] = '{3'b001, 3'b010, 3'b100, 3'b111};
      mfb_v = 1'b0;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         sel = sels[$urandom_range(0, 3)];
         n = (kind == 0) ? 4 : nbytes(sel);
         a = 32'h100 + (32'($urandom_range(0, 63)) & ~32'(n - 1));
         wd = $urandom;
         if (kind == 0) begin
            exp_lat = (HAS_FB && mfb_v && mfb_w == int'(a >> 2)) ? 1 : 6;
            exp_d = ref_load(a, 4);
         end else if (kind == 1) begin
            exp_lat = n + 2;
            exp_d = ref_load(a, n);
         end else begin
            exp_lat = n + 1;
            exp_d = wd & ((n == 4) ? 32'hFFFFFFFF : ((32'h1 << (8*n)) - 1));
         end
         run_op(kind, sel, a, wd, lat, d, sok);
         if (kind == 0) begin mfb_v = 1'b1; mfb_w = int'(a >> 2); end
         if (kind == 2) begin
            model_store(a, n, wd);
            d = ram_word(a, n);
         end
         checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_lat kind%0d a=%h got=%0d exp=%0d", i, kind, a, lat, exp_lat); end
         checks++; if (d !== exp_d) begin errors++; $display("FAIL rnd%0d_data kind%0d a=%h got=%h exp=%h", i, kind, a, d, exp_d); end
         checks++; if (!sok) begin errors++; $display("FAIL rnd%0d_stall kind%0d got=0 exp=1 until done", i, kind); end
      end
   endtask

   initial begin
      test_reset();
      for (int k = 0; k < 64; k++) poke(32'h100 + k, 8'($urandom));
      test_fetch_basic();
      test_store_load();
      test_arbitration();
      test_reset_mid_store();
      test_drop_mid_load();
      test_fetch_buf();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
